matrix_scan_reader: RTL

MATRIX_SCAN_READER -- requirements
Module: matrix_scan_reader

---
 rtl/matrix_pkg.sv | 16 +
 rtl/decoder3_8.sv | 16 +
 rtl/matrix_scan_reader.sv | 124 ++++++++++++
 3 files changed

// File: rtl/matrix_pkg.sv
// Shared definitions for the keyboard/switch matrix scanner.
//   scan_state_t : scan FSM states (settle, sample one column, close a frame)
//   MATRIX_N     : rows and columns in the matrix
//   FRAME_W      : width of one full switch image (MATRIX_N * MATRIX_N)
package matrix_pkg;

  localparam int MATRIX_N = 8;
  localparam int FRAME_W  = MATRIX_N * MATRIX_N;

  typedef enum logic [1:0] {
    ST_SETTLE     = 2'd0,
    ST_SAMPLE     = 2'd1,
    ST_FRAME_DONE = 2'd2
  } scan_state_t;

endpackage

// File: rtl/decoder3_8.sv
// 3-to-8 one-hot decoder.
//   sel    : binary index
//   en     : enable; all outputs low when 0
//   onehot : 1 << sel when enabled
module decoder3_8 (
  input  logic [2:0] sel,
  input  logic       en,
  output logic [7:0] onehot
);

  always_comb begin
    onehot = '0;
    if (en) onehot[sel] = 1'b1;
  end

endmodule

// File: rtl/matrix_scan_reader.sv
// Scans an 8x8 switch matrix one column at a time, debounces whole frames and
// hands accepted switch images to a consumer through a valid/ready slot.
//   clk         : single clock, rising edge
//   rst         : asynchronous active-low reset
//   columns_out : one-hot column drive, active-high
//   rows_in     : row sense lines, active-low (0 = switch closed)
//   frame_out   : last accepted image, bit 8*k+j = column k, row j, 1 = closed
//   frame_valid : frame_out not yet taken by the consumer
//   frame_ready : consumer takes frame_out when frame_valid is also 1
module matrix_scan_reader
  import matrix_pkg::*;
#(
  parameter int SETTLE_TICKS    = 4,
  parameter int DEBOUNCE_FRAMES = 3
) (
  input  logic                clk,
  input  logic                rst,
  output logic [MATRIX_N-1:0] columns_out,
  input  logic [MATRIX_N-1:0] rows_in,
  output logic [FRAME_W-1:0]  frame_out,
  output logic                frame_valid,
  input  logic                frame_ready
);

  localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_TICKS - 1);
  localparam logic [3:0] STABLE_MAX  = 4'(DEBOUNCE_FRAMES - 1);
  localparam logic [2:0] COL_LAST    = 3'(MATRIX_N - 1);

  // Stability counter stops at the acceptance threshold so a pending frame
  // stays eligible for as long as the consumer stalls.
  function automatic logic [3:0] sat_inc(input logic [3:0] v);
    return (v >= STABLE_MAX) ? STABLE_MAX : v + 4'd1;
  endfunction

  scan_state_t          state, state_nxt;
  logic [7:0]           settle_cnt;
  logic [2:0]           col;
  logic [FRAME_W-1:0]   shadow;
  logic [FRAME_W-1:0]   candidate;
  logic [3:0]           stable_cnt;

  logic                 do_sample;
  logic                 do_frame;
  logic                 slot_free;
  logic                 handshake;
  logic [3:0]           stable_nxt;
  logic                 accept;

  decoder3_8 u_col_dec (
    .sel    (col),
    .en     (1'b1),
    .onehot (columns_out)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_SETTLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    do_sample  = 1'b0;
    do_frame   = 1'b0;
    slot_free  = !frame_valid || frame_ready;
    handshake  = frame_valid && frame_ready;
    stable_nxt = stable_cnt;
    accept     = 1'b0;
    case (state)
      ST_SETTLE: begin
        if (settle_cnt == SETTLE_LAST) state_nxt = ST_SAMPLE;
      end
      ST_SAMPLE: begin
        do_sample = 1'b1;
        state_nxt = (col == COL_LAST) ? ST_FRAME_DONE : ST_SETTLE;
      end
      ST_FRAME_DONE: begin
        do_frame  = 1'b1;
        state_nxt = ST_SETTLE;
        // After this cycle candidate always equals shadow, so the acceptance
        // test compares the freshly scanned image against frame_out.
        stable_nxt = (shadow == candidate) ? sat_inc(stable_cnt) : 4'd0;
        accept     = (stable_nxt == STABLE_MAX) && (shadow != frame_out) && slot_free;
      end
      default: state_nxt = ST_SETTLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      settle_cnt <= '0;
      col        <= '0;
      shadow     <= '0;
      candidate  <= '0;
      stable_cnt <= '0;
      frame_out  <= '0;
      frame_valid <= 1'b0;
    end else begin
      if (state == ST_SETTLE) begin
        settle_cnt <= (settle_cnt == SETTLE_LAST) ? 8'd0 : settle_cnt + 8'd1;
      end else begin
        settle_cnt <= '0;
      end

      if (do_sample) begin
        shadow[{col, 3'b000} +: MATRIX_N] <= ~rows_in;
        if (col != COL_LAST) col <= col + 3'd1;
      end

      if (do_frame) begin
        col        <= '0;
        candidate  <= shadow;
        stable_cnt <= stable_nxt;
      end

      if (accept) begin
        frame_out   <= shadow;
        frame_valid <= 1'b1;
      end else if (handshake) begin
        frame_valid <= 1'b0;
      end
    end
  end

endmodule
